// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: RV32M multiply/divide companion to the single-cycle ALU.
//   One M-extension op per in_vld/in_rdy handshake. Multiply has a fixed
//   latency of MUL_CYCLES clocks. Divide is an iterative radix-2 restoring
//   divider (XLEN iterations plus one sign-fix clock). Divide by zero and
//   signed overflow finish in one clock. The result is held until out_rdy.
// Ports:
//   clk, rst (sync, active-low), flush (kill in-flight op)
//   in_vld/in_rdy, in_funct3, in_rs0 (a), in_rs1 (b), in_rd (tag)
//   out_vld/out_rdy, out_rd, out_data
//   busy (state != IDLE)
module alu_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 2,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_rs0,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [TAG_W-1:0] in_rd,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [TAG_W-1:0] out_rd,
   output logic [XLEN-1:0]  out_data,
   output logic             busy
);

   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       f3;        // funct3[1:0] of the accepted op
   logic [TAG_W-1:0] tag;
   logic [XLEN-1:0]  a_reg, b_reg;
   logic [XLEN-1:0]  quo, rem, dvs;
   logic             neg_q, neg_r;

   assign in_rdy = (state == IDLE) && rst && !flush;
   assign busy   = (state != IDLE);

   // Multiplier: one shared array. In IDLE it looks at the live inputs so a
   // single-cycle configuration can finish on the acceptance edge.
   logic [XLEN-1:0]          mul_a, mul_b;
   logic [1:0]               mul_f;
   logic                     sa, sb;
   logic signed [2*XLEN-1:0] ax, bx, prod;
   logic [XLEN-1:0]          mul_res;

   always_comb begin
      mul_a = (state == IDLE) ? in_rs0 : a_reg;
      mul_b = (state == IDLE) ? in_rs1 : b_reg;
      mul_f = (state == IDLE) ? in_funct3[1:0] : f3;
      // MULH: both signed; MULHSU: a signed only; MUL/MULHU: low half/unsigned
      sa = (mul_f == 2'b01) || (mul_f == 2'b10);
      sb = (mul_f == 2'b01);
      ax = {{XLEN{sa & mul_a[XLEN-1]}}, mul_a};
      bx = {{XLEN{sb & mul_b[XLEN-1]}}, mul_b};
      prod = ax * bx;
      mul_res = (mul_f == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // Divide setup on the acceptance edge: signed ops are run on magnitudes.
   logic            d_sgn, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b;

   always_comb begin
      d_sgn    = !in_funct3[0];
      a_neg    = d_sgn & in_rs0[XLEN-1];
      b_neg    = d_sgn & in_rs1[XLEN-1];
      mag_a    = a_neg ? -in_rs0 : in_rs0;
      mag_b    = b_neg ? -in_rs1 : in_rs1;
      div_zero = (in_rs1 == '0);
      div_ovf  = d_sgn && (in_rs0 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs1 == '1);
   end

   // One restoring step: shift next dividend bit into the partial remainder
   // and subtract the divisor if it fits.
   logic [XLEN:0] shl, diff;

   always_comb begin
      shl  = {rem, quo[XLEN-1]};
      diff = shl - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         f3       <= '0;
         tag      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         out_vld  <= 1'b0;
         out_data <= '0;
         out_rd   <= '0;
      end else if (flush) begin
         state    <= IDLE;
         cnt      <= '0;
         out_vld  <= 1'b0;
         out_data <= '0;
         out_rd   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_vld) begin
                  f3    <= in_funct3[1:0];
                  tag   <= in_rd;
                  a_reg <= in_rs0;
                  b_reg <= in_rs1;
                  cnt   <= '0;
                  if (!in_funct3[2]) begin
                     if (MUL_CYCLES == 1) begin
                        out_data <= mul_res;
                        out_rd   <= in_rd;
                        out_vld  <= 1'b1;
                        state    <= DONE;
                     end else begin
                        cnt   <= CNT_W'(1);
                        state <= MUL;
                     end
                  end else if (div_zero) begin
                     // quotient all-ones, remainder is the dividend
                     out_data <= in_funct3[1] ? in_rs0 : '1;
                     out_rd   <= in_rd;
                     out_vld  <= 1'b1;
                     state    <= DONE;
                  end else if (div_ovf) begin
                     out_data <= in_funct3[1] ? '0 : in_rs0;
                     out_rd   <= in_rd;
                     out_vld  <= 1'b1;
                     state    <= DONE;
                  end else begin
                     quo   <= mag_a;
                     dvs   <= mag_b;
                     rem   <= '0;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                  out_data <= mul_res;
                  out_rd   <= tag;
                  out_vld  <= 1'b1;
                  cnt      <= '0;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DIV: begin
               if (!diff[XLEN]) begin
                  rem <= diff[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b1};
               end else begin
                  rem <= shl[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b0};
               end
               if (cnt == CNT_W'(XLEN - 1)) begin
                  cnt   <= '0;
                  state <= FIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIX: begin
               // remainder follows the dividend sign, quotient the sign xor
               if (f3[1]) out_data <= neg_r ? -rem : rem;
               else       out_data <= neg_q ? -quo : quo;
               out_rd  <= tag;
               out_vld <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               if (out_rdy) begin
                  out_vld  <= 1'b0;
                  out_data <= '0;
                  out_rd   <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
